// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the LoongArch CSR unit.
//   - CSR numbers for every implemented register
//   - exception codes and field bit positions
//   - per-register masks of the architecturally writable bits
//   - masked_write helper shared by every software-writable register
package csr_pkg;

  typedef logic [13:0] csr_num_t;

  localparam csr_num_t CSR_CRMD   = 14'h000;
  localparam csr_num_t CSR_PRMD   = 14'h001;
  localparam csr_num_t CSR_ECFG   = 14'h004;
  localparam csr_num_t CSR_ESTAT  = 14'h005;
  localparam csr_num_t CSR_ERA    = 14'h006;
  localparam csr_num_t CSR_EENTRY = 14'h00C;
  localparam csr_num_t CSR_SAVE0  = 14'h030;
  localparam csr_num_t CSR_SAVE1  = 14'h031;
  localparam csr_num_t CSR_SAVE2  = 14'h032;
  localparam csr_num_t CSR_SAVE3  = 14'h033;
  localparam csr_num_t CSR_TID    = 14'h040;
  localparam csr_num_t CSR_TCFG   = 14'h041;
  localparam csr_num_t CSR_TVAL   = 14'h042;
  localparam csr_num_t CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_SYS = 6'h0B;

  // CRMD.PLV[1:0] + CRMD.IE[2] and PRMD.PPLV[1:0] + PRMD.PIE[2] share a layout,
  // so exception entry/return moves the whole [2:0] slice in one go.
  localparam int PLV_IE_MSB      = 2;
  localparam int CRMD_IE_BIT     = 2;
  localparam int ESTAT_HWI_LSB   = 2;
  localparam int ESTAT_HWI_MSB   = 9;
  localparam int ESTAT_TI_BIT    = 11;
  localparam int ESTAT_ECODE_LSB = 16;
  localparam int ESTAT_ECODE_MSB = 21;
  localparam int ESTAT_ESUB_LSB  = 22;
  localparam int ESTAT_ESUB_MSB  = 30;
  localparam int TCFG_EN_BIT     = 0;
  localparam int TCFG_PERIOD_BIT = 1;
  localparam int TICLR_CLR_BIT   = 0;

  // Software-writable bits. Anything outside these masks is either read-only
  // (hardware-owned) or reserved and reads 0.
  localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF; // PLV,IE,DA,PG,DATF,DATM
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007; // PPLV,PIE
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF; // LIE[9:0],LIE[12:11]
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003; // IS[1:0] soft interrupts
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0; // VA[31:6]
  localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

  function automatic logic [31:0] masked_write(
    input logic [31:0] old_val,
    input logic [31:0] wdata,
    input logic [31:0] wmask,
    input logic [31:0] field_mask
  );
    logic [31:0] m;
    m = wmask & field_mask;
    return (old_val & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// csr_timer: TCFG / TVAL constant timer.
//   clk         in   single clock
//   resetn      in   synchronous active-low reset
//   i_tcfg_we   in   write strobe qualified for the TCFG number
//   i_wdata     in   CSR write data
//   i_wmask     in   CSR write mask
//   o_tcfg      out  TCFG value (zero-extended to 32 bits)
//   o_tval      out  TVAL value (zero-extended to 32 bits)
//   o_ti_set    out  single-cycle pulse on timer expiry
module csr_timer
  import csr_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_tcfg_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_wmask,
  output logic [31:0] o_tcfg,
  output logic [31:0] o_tval,
  output logic        o_ti_set
);

  logic [TIMER_W-1:0] r_tcfg;
  logic [TIMER_W-1:0] r_tval;
  logic               r_stop;

  logic [TIMER_W-1:0] w_tcfg_next;
  logic [TIMER_W-1:0] w_load_val;
  logic [TIMER_W-1:0] w_reload_val;
  logic               w_running;

  assign w_tcfg_next  = (r_tcfg & ~i_wmask[TIMER_W-1:0]) | (i_wdata[TIMER_W-1:0] & i_wmask[TIMER_W-1:0]);
  // InitVal occupies [TIMER_W-1:2]; the count starts from InitVal*4.
  assign w_load_val   = {w_tcfg_next[TIMER_W-1:2], 2'b00};
  assign w_reload_val = {r_tcfg[TIMER_W-1:2], 2'b00};
  assign w_running    = r_tcfg[TCFG_EN_BIT] && !r_stop;

  // Expiry is the cycle spent at zero; the decrement never wraps on its own.
  assign o_ti_set = w_running && (r_tval == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tcfg <= '0;
      r_tval <= '0;
      r_stop <= 1'b0;
    end else if (i_tcfg_we) begin
      r_tcfg <= w_tcfg_next;
      r_tval <= w_load_val;
      r_stop <= 1'b0;
    end else if (o_ti_set) begin
      if (r_tcfg[TCFG_PERIOD_BIT]) begin
        r_tval <= w_reload_val;
      end else begin
        // One-shot: park at all-ones until software rewrites TCFG.
        r_tval <= '1;
        r_stop <= 1'b1;
      end
    end else if (w_running) begin
      r_tval <= r_tval - TIMER_W'(1);
    end
  end

  assign o_tcfg = 32'(r_tcfg);
  assign o_tval = 32'(r_tval);

endmodule

// File: rtl/csr_unit.sv
// csr_unit: LoongArch CSR file and exception / ertn commit point.
//   clk, resetn                 single clock, synchronous active-low reset
//   csr_rnum / csr_rvalue       combinational read port (0 for unimplemented numbers)
//   csr_we/wnum/wdata/wmask     masked write port from WB
//   wb_ex/ecode/esubcode/pc     exception commit from WB
//   ertn_flush                  ertn commit from WB
//   hw_int_in                   level hardware interrupts -> ESTAT.IS[9:2]
//   ex_entry, era_pc            IF redirect targets (EENTRY, ERA)
//   has_int                     pending enabled interrupt and CRMD.IE set
module csr_unit
  import csr_pkg::*;
#(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        csr_we,
  input  logic [13:0] csr_wnum,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] csr_wmask,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int
);

  logic [31:0] r_crmd, r_prmd, r_ecfg, r_estat, r_era, r_eentry, r_tid;
  logic [31:0] w_crmd_next, w_prmd_next, w_ecfg_next, w_estat_next;
  logic [31:0] w_era_next, w_eentry_next, w_tid_next;
  logic [31:0] w_save [4];
  logic [31:0] w_tcfg, w_tval;
  logic        w_tcfg_we, w_ticlr, w_ti_set;

  assign w_tcfg_we = csr_we && (csr_wnum == CSR_TCFG);
  assign w_ticlr   = csr_we && (csr_wnum == CSR_TICLR)
                     && csr_wdata[TICLR_CLR_BIT] && csr_wmask[TICLR_CLR_BIT];

  csr_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .i_tcfg_we (w_tcfg_we),
    .i_wdata   (csr_wdata),
    .i_wmask   (csr_wmask),
    .o_tcfg    (w_tcfg),
    .o_tval    (w_tval),
    .o_ti_set  (w_ti_set)
  );

  // Software write first, then ex/ertn overwrite only the fields they own,
  // so a colliding write loses those fields but keeps the rest.
  always_comb begin
    w_crmd_next   = r_crmd;
    w_prmd_next   = r_prmd;
    w_ecfg_next   = r_ecfg;
    w_estat_next  = r_estat;
    w_era_next    = r_era;
    w_eentry_next = r_eentry;
    w_tid_next    = r_tid;

    if (csr_we) begin
      case (csr_wnum)
        CSR_CRMD:   w_crmd_next   = masked_write(r_crmd,   csr_wdata, csr_wmask, CRMD_WMASK);
        CSR_PRMD:   w_prmd_next   = masked_write(r_prmd,   csr_wdata, csr_wmask, PRMD_WMASK);
        CSR_ECFG:   w_ecfg_next   = masked_write(r_ecfg,   csr_wdata, csr_wmask, ECFG_WMASK);
        CSR_ESTAT:  w_estat_next  = masked_write(r_estat,  csr_wdata, csr_wmask, ESTAT_WMASK);
        CSR_ERA:    w_era_next    = masked_write(r_era,    csr_wdata, csr_wmask, FULL_WMASK);
        CSR_EENTRY: w_eentry_next = masked_write(r_eentry, csr_wdata, csr_wmask, EENTRY_WMASK);
        CSR_TID:    w_tid_next    = masked_write(r_tid,    csr_wdata, csr_wmask, FULL_WMASK);
        default: ;
      endcase
    end

    w_estat_next[ESTAT_HWI_MSB:ESTAT_HWI_LSB] = hw_int_in;
    // Expiry beats a same-cycle TICLR so no timer event is lost.
    if (w_ti_set) begin
      w_estat_next[ESTAT_TI_BIT] = 1'b1;
    end else if (w_ticlr) begin
      w_estat_next[ESTAT_TI_BIT] = 1'b0;
    end

    if (wb_ex) begin
      w_prmd_next[PLV_IE_MSB:0] = r_crmd[PLV_IE_MSB:0];
      w_crmd_next[PLV_IE_MSB:0] = '0;
      w_estat_next[ESTAT_ECODE_MSB:ESTAT_ECODE_LSB] = wb_ecode;
      w_estat_next[ESTAT_ESUB_MSB:ESTAT_ESUB_LSB]   = wb_esubcode;
      w_era_next = wb_pc;
    end else if (ertn_flush) begin
      w_crmd_next[PLV_IE_MSB:0] = r_prmd[PLV_IE_MSB:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_crmd   <= 32'h0000_0008;
      r_prmd   <= '0;
      r_ecfg   <= '0;
      r_estat  <= '0;
      r_era    <= '0;
      r_eentry <= '0;
      r_tid    <= TID_RST;
    end else begin
      r_crmd   <= w_crmd_next;
      r_prmd   <= w_prmd_next;
      r_ecfg   <= w_ecfg_next;
      r_estat  <= w_estat_next;
      r_era    <= w_era_next;
      r_eentry <= w_eentry_next;
      r_tid    <= w_tid_next;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_save
    localparam csr_num_t SAVE_NUM = CSR_SAVE0 + csr_num_t'(gi);
    logic [31:0] r_save;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_save <= '0;
      end else if (csr_we && (csr_wnum == SAVE_NUM)) begin
        r_save <= masked_write(r_save, csr_wdata, csr_wmask, FULL_WMASK);
      end
    end

    assign w_save[gi] = r_save;
  end

  always_comb begin
    csr_rvalue = '0;
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = r_crmd;
      CSR_PRMD:   csr_rvalue = r_prmd;
      CSR_ECFG:   csr_rvalue = r_ecfg;
      CSR_ESTAT:  csr_rvalue = r_estat;
      CSR_ERA:    csr_rvalue = r_era;
      CSR_EENTRY: csr_rvalue = r_eentry;
      CSR_SAVE0:  csr_rvalue = w_save[0];
      CSR_SAVE1:  csr_rvalue = w_save[1];
      CSR_SAVE2:  csr_rvalue = w_save[2];
      CSR_SAVE3:  csr_rvalue = w_save[3];
      CSR_TID:    csr_rvalue = r_tid;
      CSR_TCFG:   csr_rvalue = w_tcfg;
      CSR_TVAL:   csr_rvalue = w_tval;
      default:    csr_rvalue = '0;
    endcase
  end

  assign ex_entry = r_eentry;
  assign era_pc   = r_era;
  assign has_int  = (|(r_estat[12:0] & r_ecfg[12:0])) && r_crmd[CRMD_IE_BIT];

endmodule
